// File: rtl/multiword_add_ctrl_pkg.sv
// Shared types and constants for the slice-serial multiword adder.
// Latency: n/a (types only).
// Backpressure: n/a.
`timescale 1ns/1ps
package multiword_add_ctrl_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_ctrl_adder16_ci.sv
// 16-bit combinational adder with carry-in and carry-out, shared across slices.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
`timescale 1ns/1ps
module adder16_ci
    import multiword_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule

// File: rtl/multiword_add_ctrl.sv
// Slice-serial add/subtract of NSLICES x 16-bit operands through one 16-bit adder.
// Latency: NSLICES+1 cycles from the Start cycle to the Done pulse.
// Backpressure: Start is ignored while Busy; it is accepted in IDLE and DONE only.
`timescale 1ns/1ps
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter int NSLICES = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Sub,
    input  logic [SLICE_W*NSLICES-1:0] A,
    input  logic [SLICE_W*NSLICES-1:0] B,
    output logic [SLICE_W*NSLICES-1:0] Sum,
    output logic                       CO,
    output logic                       OVF,
    output logic                       Busy,
    output logic                       Done
);

    localparam int W     = SLICE_W * NSLICES;
    localparam int IDX_W = $clog2(NSLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               sub_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               last;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] s_sl;
    logic               c_sl;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry loaded from Sub.
    assign last = (idx == LAST_IDX);
    assign a_sl = a_q[SLICE_W*int'(idx) +: SLICE_W];
    assign b_sl = b_q[SLICE_W*int'(idx) +: SLICE_W] ^ {SLICE_W{sub_q}};

    adder16_ci u_adder (
        .a  (a_sl),
        .b  (b_sl),
        .ci (carry),
        .s  (s_sl),
        .co (c_sl)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            Sum   <= '0;
            CO    <= 1'b0;
            OVF   <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= Sub;
            idx   <= '0;
            carry <= Sub;
        end else if (state == RUN) begin
            Sum[SLICE_W*int'(idx) +: SLICE_W] <= s_sl;
            carry <= c_sl;
            idx   <= idx + 1'b1;
            if (last) begin
                CO  <= c_sl;
                OVF <= (a_sl[SLICE_W-1] == b_sl[SLICE_W-1]) &&
                       (s_sl[SLICE_W-1] != a_sl[SLICE_W-1]);
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench: directed cases on the 4-slice instance plus a random
// regression across 2-, 4- and 8-slice instances against a wide-arithmetic model.
`timescale 1ns/1ps
module tb_multiword_add_ctrl;

    logic clk;
    logic reset;

    logic         start2, sub2, co2, ovf2, busy2, done2;
    logic [31:0]  a2, b2, sum2;
    logic         start4, sub4, co4, ovf4, busy4, done4;
    logic [63:0]  a4, b4, sum4;
    logic         start8, sub8, co8, ovf8, busy8, done8;
    logic [127:0] a8, b8, sum8;

    int checks;
    int failures;

    multiword_add_ctrl #(.NSLICES(2)) u2 (
        .Clk(clk), .Reset(reset), .Start(start2), .Sub(sub2), .A(a2), .B(b2),
        .Sum(sum2), .CO(co2), .OVF(ovf2), .Busy(busy2), .Done(done2)
    );
    multiword_add_ctrl #(.NSLICES(4)) u4 (
        .Clk(clk), .Reset(reset), .Start(start4), .Sub(sub4), .A(a4), .B(b4),
        .Sum(sum4), .CO(co4), .OVF(ovf4), .Busy(busy4), .Done(done4)
    );
    multiword_add_ctrl #(.NSLICES(8)) u8 (
        .Clk(clk), .Reset(reset), .Start(start8), .Sub(sub8), .A(a8), .B(b8),
        .Sum(sum8), .CO(co8), .OVF(ovf8), .Busy(busy8), .Done(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-word modular arithmetic, signed overflow from operand/result signs.
    function automatic void ref_add(input int n, input logic [127:0] a, input logic [127:0] b,
                                    input logic sub, output logic [127:0] s,
                                    output logic co, output logic ovf);
        int w;
        logic [128:0] mask, av, bv, full;
        w    = 16 * n;
        mask = (129'd1 << w) - 129'd1;
        av   = {1'b0, a} & mask;
        bv   = {1'b0, b} & mask;
        if (sub) full = av + ((~bv) & mask) + 129'd1;
        else     full = av + bv;
        co = full[w];
        s  = full[127:0] & mask[127:0];
        if (sub) ovf = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
        else     ovf = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    function automatic logic [127:0] rand_word();
        logic [127:0] v;
        int m;
        m = $urandom_range(0, 7);
        v = {$urandom, $urandom, $urandom, $urandom};
        if (m == 0)      v = '1;
        else if (m == 1) v = '0;
        else if (m == 2) v = 128'd1 << $urandom_range(0, 127);
        else if (m == 3) v = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
        return v;
    endfunction

    // Issue one operation on the 4-slice instance; lat = edges until Done (0 on timeout).
    task automatic do_op4(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          output int lat);
        @(negedge clk);
        a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) start4 = 1'b0;
            if (done4) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start2 = 0; start4 = 0; start8 = 0;
        sub2 = 0; sub4 = 0; sub8 = 0;
        a2 = '0; b2 = '0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sum2, co2, ovf2, busy2, done2} !== '0) begin
            failures++;
            $display("FAIL reset_n2 got sum=%h co=%b ovf=%b busy=%b done=%b exp all zero",
                     sum2, co2, ovf2, busy2, done2);
        end
        checks++;
        if ({sum4, co4, ovf4, busy4, done4} !== '0) begin
            failures++;
            $display("FAIL reset_n4 got sum=%h co=%b ovf=%b busy=%b done=%b exp all zero",
                     sum4, co4, ovf4, busy4, done4);
        end
        checks++;
        if ({sum8, co8, ovf8, busy8, done8} !== '0) begin
            failures++;
            $display("FAIL reset_n8 got sum=%h co=%b ovf=%b busy=%b done=%b exp all zero",
                     sum8, co8, ovf8, busy8, done8);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_carry_chain();
        int lat;
        do_op4(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency got=%0d exp=5", lat);
        end
        checks++;
        if (sum4 !== 64'h0000_0000_0001_0000 || co4 !== 1'b0 || ovf4 !== 1'b0) begin
            failures++;
            $display("FAIL carry_one got sum=%h co=%b ovf=%b exp sum=0000000000010000 co=0 ovf=0",
                     sum4, co4, ovf4);
        end
        @(posedge clk); #1;
        checks++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            failures++;
            $display("FAIL done_width got done=%b busy=%b exp done=0 busy=0", done4, busy4);
        end
        do_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat != 5 || sum4 !== 64'h0 || co4 !== 1'b1 || ovf4 !== 1'b0) begin
            failures++;
            $display("FAIL carry_ripple got lat=%0d sum=%h co=%b ovf=%b exp lat=5 sum=0 co=1 ovf=0",
                     lat, sum4, co4, ovf4);
        end
    endtask

    task automatic test_overflow_sub();
        int lat;
        do_op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
        checks++;
        if (lat != 5 || sum4 !== 64'h8000_0000_0000_0000 || co4 !== 1'b0 || ovf4 !== 1'b1) begin
            failures++;
            $display("FAIL signed_ovf got lat=%0d sum=%h co=%b ovf=%b exp sum=8000000000000000 co=0 ovf=1",
                     lat, sum4, co4, ovf4);
        end
        do_op4(64'h5, 64'h7, 1'b1, lat);
        checks++;
        if (lat != 5 || sum4 !== 64'hFFFF_FFFF_FFFF_FFFE || co4 !== 1'b0 || ovf4 !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow got lat=%0d sum=%h co=%b ovf=%b exp sum=fffffffffffffffe co=0 ovf=0",
                     lat, sum4, co4, ovf4);
        end
    endtask

    task automatic test_start_during_run();
        logic [127:0] es;
        logic eco, eovf;
        logic [63:0] ga, gb, s_at;
        logic co_at, ovf_at;
        int lat, ndone;
        ga = {$urandom, $urandom};
        gb = {$urandom, $urandom};
        ref_add(4, {64'd0, ga}, {64'd0, gb}, 1'b0, es, eco, eovf);
        @(negedge clk);
        a4 = ga; b4 = gb; sub4 = 1'b0; start4 = 1'b1;
        lat = 0; ndone = 0; s_at = '0; co_at = 1'b0; ovf_at = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (i <= 3) begin
                start4 = 1'b1;
                a4 = {$urandom, $urandom};
                b4 = {$urandom, $urandom};
                sub4 = 1'($urandom_range(0, 1));
            end else begin
                start4 = 1'b0;
            end
            if (done4) begin
                ndone++;
                if (lat == 0) begin
                    lat = i; s_at = sum4; co_at = co4; ovf_at = ovf4;
                end
            end
        end
        checks++;
        if (ndone != 1 || lat != 5) begin
            failures++;
            $display("FAIL run_ignore_start got dones=%0d lat=%0d exp dones=1 lat=5", ndone, lat);
        end
        checks++;
        if (s_at !== es[63:0] || co_at !== eco || ovf_at !== eovf) begin
            failures++;
            $display("FAIL run_operand_latch got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b",
                     s_at, co_at, ovf_at, es[63:0], eco, eovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] e1, e2;
        logic c1, v1, c2, v2;
        logic [63:0] x1, y1, x2, y2, s1, s2;
        logic busy_after;
        int first, second;
        x1 = {$urandom, $urandom}; y1 = {$urandom, $urandom};
        x2 = {$urandom, $urandom}; y2 = {$urandom, $urandom};
        ref_add(4, {64'd0, x1}, {64'd0, y1}, 1'b0, e1, c1, v1);
        ref_add(4, {64'd0, x2}, {64'd0, y2}, 1'b1, e2, c2, v2);
        @(negedge clk);
        a4 = x1; b4 = y1; sub4 = 1'b0; start4 = 1'b1;
        first = 0; second = 0; s1 = '0; s2 = '0; busy_after = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                a4 = x2; b4 = y2; sub4 = 1'b1;
            end
            if (first != 0 && i == first + 1) begin
                busy_after = busy4;
                start4 = 1'b0;
            end
            if (done4) begin
                if (first == 0) begin
                    first = i; s1 = sum4;
                end else if (second == 0) begin
                    second = i; s2 = sum4;
                end
            end
        end
        start4 = 1'b0;
        checks++;
        if (first != 5 || second != 10 || busy_after !== 1'b1) begin
            failures++;
            $display("FAIL b2b_timing got first=%0d second=%0d busy=%b exp first=5 second=10 busy=1",
                     first, second, busy_after);
        end
        checks++;
        if (s1 !== e1[63:0] || s2 !== e2[63:0]) begin
            failures++;
            $display("FAIL b2b_results got s1=%h s2=%h exp s1=%h s2=%h", s1, s2, e1[63:0], e2[63:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (co4 !== c2 || ovf4 !== v2) begin
            failures++;
            $display("FAIL b2b_flags got co=%b ovf=%b exp co=%b ovf=%b", co4, ovf4, c2, v2);
        end
    endtask

    task automatic test_reset_midrun();
        logic [127:0] es;
        logic eco, eovf;
        logic [63:0] ga, gb;
        int ndone, lat;
        @(negedge clk);
        a4 = 64'h1111_2222_3333_4444; b4 = 64'h0101_0101_0101_0101; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sum4, co4, ovf4, busy4, done4} !== '0) begin
            failures++;
            $display("FAIL reset_midrun got sum=%h co=%b ovf=%b busy=%b done=%b exp all zero",
                     sum4, co4, ovf4, busy4, done4);
        end
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done4 || busy4) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL reset_abandon got active_cycles=%0d exp 0", ndone);
        end
        ga = {$urandom, $urandom}; gb = {$urandom, $urandom};
        ref_add(4, {64'd0, ga}, {64'd0, gb}, 1'b1, es, eco, eovf);
        do_op4(ga, gb, 1'b1, lat);
        checks++;
        if (lat != 5 || sum4 !== es[63:0] || co4 !== eco || ovf4 !== eovf) begin
            failures++;
            $display("FAIL after_reset got lat=%0d sum=%h co=%b ovf=%b exp lat=5 sum=%h co=%b ovf=%b",
                     lat, sum4, co4, ovf4, es[63:0], eco, eovf);
        end
    endtask

    task automatic test_hold();
        logic [127:0] e1, e2;
        logic c1, v1, c2, v2;
        logic [63:0] x, y;
        int lat, bad;
        x = 64'hDEAD_BEEF_0BAD_F00D; y = 64'h1234_0000_FFFF_0001;
        ref_add(4, {64'd0, x}, {64'd0, y}, 1'b0, e1, c1, v1);
        do_op4(x, y, 1'b0, lat);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = {$urandom, $urandom}; b4 = {$urandom, $urandom}; sub4 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (sum4 !== e1[63:0] || co4 !== c1 || ovf4 !== v1 || busy4 || done4) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_hold got bad_cycles=%0d exp 0 (sum=%h exp %h)", bad, sum4, e1[63:0]);
        end
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        ref_add(4, {64'd0, x}, {64'd0, y}, 1'b1, e2, c2, v2);
        @(negedge clk);
        a4 = x; b4 = y; sub4 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++;
        if (sum4 !== e1[63:0] || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL no_clear_on_start got sum=%h busy=%b exp sum=%h busy=1", sum4, busy4, e1[63:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (sum4 !== {e1[63:16], e2[15:0]}) begin
            failures++;
            $display("FAIL partial_sum got sum=%h exp %h", sum4, {e1[63:16], e2[15:0]});
        end
        lat = 0;
        for (int i = 3; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 5 || sum4 !== e2[63:0] || co4 !== c2 || ovf4 !== v2) begin
            failures++;
            $display("FAIL hold_next_op got lat=%0d sum=%h co=%b ovf=%b exp lat=5 sum=%h co=%b ovf=%b",
                     lat, sum4, co4, ovf4, e2[63:0], c2, v2);
        end
    endtask

    task automatic test_random(input int nops);
        logic [127:0] ra, rb, es;
        logic rs, eco, eovf;
        int got2, got4, got8, lat2, lat4, lat8;
        for (int op = 0; op < nops; op++) begin
            ra = rand_word(); rb = rand_word(); rs = 1'($urandom_range(0, 1));
            @(negedge clk);
            a2 = ra[31:0]; b2 = rb[31:0]; sub2 = rs; start2 = 1'b1;
            a4 = ra[63:0]; b4 = rb[63:0]; sub4 = rs; start4 = 1'b1;
            a8 = ra;       b8 = rb;       sub8 = rs; start8 = 1'b1;
            got2 = 0; got4 = 0; got8 = 0; lat2 = 0; lat4 = 0; lat8 = 0;
            for (int i = 1; i <= 12; i++) begin
                @(posedge clk); #1;
                if (i == 1) begin
                    start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
                end
                if (done2) begin
                    got2++; lat2 = i;
                    ref_add(2, {96'd0, ra[31:0]}, {96'd0, rb[31:0]}, rs, es, eco, eovf);
                    checks++;
                    if (sum2 !== es[31:0] || co2 !== eco || ovf2 !== eovf) begin
                        failures++;
                        $display("FAIL rand_n2 op=%0d got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b",
                                 op, sum2, co2, ovf2, es[31:0], eco, eovf);
                    end
                end
                if (done4) begin
                    got4++; lat4 = i;
                    ref_add(4, {64'd0, ra[63:0]}, {64'd0, rb[63:0]}, rs, es, eco, eovf);
                    checks++;
                    if (sum4 !== es[63:0] || co4 !== eco || ovf4 !== eovf) begin
                        failures++;
                        $display("FAIL rand_n4 op=%0d got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b",
                                 op, sum4, co4, ovf4, es[63:0], eco, eovf);
                    end
                end
                if (done8) begin
                    got8++; lat8 = i;
                    ref_add(8, ra, rb, rs, es, eco, eovf);
                    checks++;
                    if (sum8 !== es || co8 !== eco || ovf8 !== eovf) begin
                        failures++;
                        $display("FAIL rand_n8 op=%0d got sum=%h co=%b ovf=%b exp sum=%h co=%b ovf=%b",
                                 op, sum8, co8, ovf8, es, eco, eovf);
                    end
                end
            end
            checks++;
            if (got2 != 1 || got4 != 1 || got8 != 1 || lat2 != 3 || lat4 != 5 || lat8 != 9) begin
                failures++;
                $display("FAIL rand_done op=%0d got dones=%0d/%0d/%0d lat=%0d/%0d/%0d exp dones=1/1/1 lat=3/5/9",
                         op, got2, got4, got8, lat2, lat4, lat8);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_carry_chain();
        test_overflow_sub();
        test_start_during_run();
        test_back_to_back();
        test_reset_midrun();
        test_hold();
        test_random(3400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiword_add_ctrl.md
MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

Interface
REQ-001 The block SHALL have parameter NSLICES, default 4, giving the number of 16-bit slices per operation (legal 2..8).
REQ-002 The block SHALL have input Clk, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input Reset, 1 bit, synchronous and active-high.
REQ-004 The block SHALL have input Start, 1 bit, which requests an operation and is sampled on a rising edge of Clk.
REQ-005 The block SHALL have input Sub, 1 bit: 0 selects A+B, 1 selects A-B; it is sampled together with Start.
REQ-006 The block SHALL have inputs A and B, each 16*NSLICES bits, holding the operands; they are sampled together with Start.
REQ-007 The block SHALL have output Sum, 16*NSLICES bits, the registered result.
REQ-008 The block SHALL have output CO, 1 bit, the carry out of the top slice (for Sub, 1 means no borrow).
REQ-009 The block SHALL have output OVF, 1 bit, the two's-complement signed overflow of the full-width result.
REQ-010 The block SHALL have output Busy, 1 bit, high while slices are being computed.
REQ-011 The block SHALL have output Done, 1 bit, a one-cycle pulse when the result is valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with Start=1, the block SHALL latch A, B and Sub, clear the slice index to 0, load the carry register with Sub, and go to RUN.
REQ-014 In RUN, each cycle SHALL compute exactly one slice k through the shared 16-bit adder: operands A[16k+15:16k] and (Sub ? ~B : B) slice k, carry-in from the carry register.
REQ-015 In each RUN cycle, the block SHALL write slice k of Sum, store the slice carry-out in the carry register, and increment k.
REQ-016 After slice NSLICES-1, the block SHALL go to DONE, set CO to the final carry, and set OVF = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the possibly inverted B.
REQ-017 In DONE, Done SHALL be 1 for exactly one cycle. If Start=1 in DONE, the block SHALL accept a new operation exactly as in REQ-013 (back-to-back). Otherwise it SHALL return to IDLE.
REQ-018 Latency SHALL be NSLICES+1 cycles: Done is high in the cycle that begins NSLICES+1 rising edges after the edge that sampled Start.
REQ-019 Busy SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-020 Start SHALL be ignored while in RUN; latched operands SHALL be unaffected by changes to A, B or Sub during RUN.
REQ-021 Sum, CO and OVF SHALL hold their last result until the next accepted Start, and SHALL hold it through IDLE.
REQ-022 On an accepted Start, the block SHALL NOT clear Sum; upper slices keep old data until overwritten.
REQ-023 All arithmetic SHALL be modulo 2^(16*NSLICES), and the carry SHALL propagate only through the carry register between cycles.

Reset
REQ-024 Reset=1 SHALL force state to IDLE, slice index to 0, the carry register to 0, the operand registers to 0, Sum to 0, and CO, OVF, Busy and Done to 0 on the next rising edge.
REQ-025 Reset SHALL take priority over Start. A reset during RUN or DONE SHALL abandon the operation with no Done pulse.

Structure
REQ-026 A shared package SHALL hold the state enum typedef (IDLE, RUN, DONE) and the constant SLICE_W = 16.
REQ-027 The block SHALL instantiate exactly one sub-module, adder16_ci: a combinational 16-bit adder with carry-in and carry-out, used once per cycle.
REQ-028 The implementation SHALL NOT contain any adder wider than 16 bits.

Verification
REQ-029 With NSLICES=4, Start, A=0x0000_0000_0000_FFFF, B=0x1, Sub=0: the bench SHALL see Sum=0x0000_0000_0001_0000, CO=0, OVF=0, and Done exactly 5 cycles after Start.
REQ-030 With A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Sub=0: the bench SHALL see Sum=0, CO=1, OVF=0 (carry ripples through all slices).
REQ-031 With A=0x7FFF_FFFF_FFFF_FFFF, B=0x1: the bench SHALL see OVF=1. With A=0x5, B=0x7, Sub=1: it SHALL see Sum=0xFFFF_FFFF_FFFF_FFFE, CO=0.
REQ-032 Driving Start and changing A and B during RUN: the bench SHALL see the result unchanged and no extra Done. Start held high through DONE: the second result follows with no idle cycle.
REQ-033 Asserting Reset in the second RUN cycle: on the next edge the bench SHALL see all outputs 0, state IDLE, and no Done. A later Start SHALL complete correctly.
REQ-034 A random regression of at least 10k operations with NSLICES in {2, 4, 8} SHALL compare Sum, CO and OVF against a reference model.
